// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds the default data/address width, the access-size encodings, the FSM
// state encodings and the alignment rule used to reject requests.
package mem_access_unit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: purely combinational byte-lane logic.
// Ports:
//   size        - access size (byte/half/word)
//   offset      - byte offset inside the word (addr[1:0])
//   is_unsigned - zero-extend loads when 1, sign-extend when 0
//   word        - word captured from memory
//   store_data  - store data, value in the low bits
//   merged      - word to write back: store lanes merged into 'word'
//   load_value  - extracted and extended load result
// Lanes are little-endian: byte k lives in bits 8k+7:8k.
module lane_align #(
  parameter int WIDTH = mem_access_unit_pkg::WIDTH
) (
  input  logic [1:0]       size,
  input  logic [1:0]       offset,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] load_value
);
  import mem_access_unit_pkg::*;

  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half accesses are aligned, so only offset[1] picks the half.
  assign byte_pos = {offset, 3'b000};
  assign half_pos = {offset[1], 4'b0000};
  assign byte_sel = word[byte_pos +: 8];
  assign half_sel = word[half_pos +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    merged     = word;
    load_value = word;
    case (size)
      SIZE_BYTE: begin
        merged[byte_pos +: 8] = store_data[7:0];
        load_value = {{(WIDTH-8){~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        merged[half_pos +: 16] = store_data[15:0];
        load_value = {{(WIDTH-16){~is_unsigned & half_sel[15]}}, half_sel};
      end
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of a word-only
// data memory. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   req_valid/write/size/      - access request from the pipeline, held
//   unsigned/addr/wdata          stable by the requester while stall=1
//   stall                      - pipeline freeze while an access is in flight
//   resp_valid                 - one-cycle completion pulse
//   resp_rdata                 - extended load result (zero for stores/errors)
//   misalign_err               - completion of a rejected request
//   dmem_we/addr/wdata/rdata   - word-only data-memory port
module mem_access_unit #(
  parameter int WIDTH = mem_access_unit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             misalign_err,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata
);
  import mem_access_unit_pkg::*;

  state_e           state, state_next;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [1:0]       size_q;
  logic             write_q, unsigned_q;
  logic             req_err, lat_err;
  logic [WIDTH-1:0] merged, load_value;

  assign req_err = is_misaligned(req_size, req_addr[1:0]);
  assign lat_err = is_misaligned(size_q, addr_q[1:0]);

  lane_align #(.WIDTH(WIDTH)) u_lane_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .word        (rdata_q),
    .store_data  (wdata_q),
    .merged      (merged),
    .load_value  (load_value)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Latched request and captured read word.
  always_ff @(posedge clk) begin
    // NOTE: the request registers are cleared on reset so dmem_addr and
    // dmem_wdata never show X, even before the first access.
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= SIZE_BYTE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
      end
      if (state == RD) rdata_q <= dmem_rdata;
    end
  end

  // Next-state logic. Word stores skip the read; rejected requests go
  // straight to DONE so they never touch memory.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err)                                 state_next = DONE;
        else if (req_write && req_size == SIZE_WORD) state_next = WR;
        else                                         state_next = RD;
      end
      RD:      state_next = write_q ? WR : DONE;
      WR:      state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. dmem_we is gated by rst so a reset landing in WR cancels the
  // write in that same cycle.
  always_comb begin
    stall        = (state == IDLE && req_valid) || state == RD || state == WR;
    resp_valid   = state == DONE;
    misalign_err = state == DONE && lat_err;
    resp_rdata   = '0;
    if (state == DONE && !write_q && !lat_err) resp_rdata = load_value;
    dmem_we      = state == WR && !rst;
    dmem_addr    = {addr_q[WIDTH-1:2], 2'b00};
    dmem_wdata   = merged;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed requests push their
// expected response into a queue; a monitor pops and compares on resp_valid.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, misalign_err, dmem_we;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata)
  );

  // Word-only memory model: combinational read, write on the clock edge.
  logic [31:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;
  int unsigned cycle = 0;
  int unsigned we_count = 0;

  assign dmem_rdata = mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (dmem_we)     mem[dmem_addr[7:2]] <= dmem_wdata;
    else if (pre_en) mem[pre_idx] <= pre_data;
    cycle <= cycle + 1;
    if (dmem_we) we_count <= we_count + 1;
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int unsigned accept;
    int unsigned lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_err"}, 32'(misalign_err), 32'(e.err));
        check({e.name, "_lat"}, cycle - e.accept, e.lat);
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_idx  = idx[5:0];
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Bounded wait for the completion pulse, then step back into IDLE.
  task automatic wait_resp(input string name);
    int n = 0;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(resp_valid), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int unsigned lat);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    exp_q.push_back('{name, exp_rd, exp_err, cycle, lat});
    #1 check({name, "_stall"}, 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wc;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_BYTE;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);

    // Loads.
    preload(4, 32'h1122_3344);
    do_req("ld_b_s", 1'b0, SIZE_BYTE, 1'b0, 32'h12, '0, 32'h0000_0022, 1'b0, 2);
    preload(4, 32'h8899_AABB);
    do_req("ld_h_s", 1'b0, SIZE_HALF, 1'b0, 32'h12, '0, 32'hFFFF_8899, 1'b0, 2);
    do_req("ld_h_u", 1'b0, SIZE_HALF, 1'b1, 32'h12, '0, 32'h0000_8899, 1'b0, 2);
    do_req("ld_b_neg", 1'b0, SIZE_BYTE, 1'b0, 32'h10, '0, 32'hFFFF_FFBB, 1'b0, 2);
    do_req("ld_b_u", 1'b0, SIZE_BYTE, 1'b1, 32'h13, '0, 32'h0000_0088, 1'b0, 2);
    do_req("ld_w", 1'b0, SIZE_WORD, 1'b0, 32'h10, '0, 32'h8899_AABB, 1'b0, 2);

    // Sub-word stores (upper store-data bits must be ignored).
    preload(8, 32'hAABB_CCDD);
    wc = we_count;
    do_req("st_b", 1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'hFFFF_FF5A, '0, 1'b0, 3);
    check("st_b_we_count", we_count - wc, 32'd1);
    check("st_b_mem", mem[8], 32'hAABB_5ADD);
    do_req("st_h", 1'b1, SIZE_HALF, 1'b0, 32'h22, 32'hABCD_1234, '0, 1'b0, 3);
    check("st_h_mem", mem[8], 32'h1234_5ADD);

    // Rejected requests: no write, memory untouched.
    preload(1, 32'h0BAD_F00D);
    wc = we_count;
    do_req("ld_w_mis", 1'b0, SIZE_WORD, 1'b0, 32'h06, '0, '0, 1'b1, 1);
    do_req("st_h_mis", 1'b1, SIZE_HALF, 1'b0, 32'h21, 32'h0000_FFFF, '0, 1'b1, 1);
    do_req("rsvd", 1'b0, SIZE_RSVD, 1'b0, 32'h10, '0, '0, 1'b1, 1);
    check("mis_we_count", we_count - wc, 32'd0);
    check("mis_mem1", mem[1], 32'h0BAD_F00D);
    check("mis_mem8", mem[8], 32'h1234_5ADD);

    // Reset during WR of a sub-word store: access dropped silently.
    preload(12, 32'h0102_0304);
    wc = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_BYTE;
    req_unsigned = 1'b0; req_addr = 32'h30; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_wr_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1 check("rst_wr_we", 32'(dmem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wr_idle_stall", 32'(stall), 32'd0);
    check("rst_wr_idle_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("rst_wr_no_resp", 32'(resp_valid), 32'd0);
    check("rst_wr_we_count", we_count - wc, 32'd0);
    check("rst_wr_mem", mem[12], 32'h0102_0304);

    // Back-to-back word store then word load from the same address.
    wc = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD;
    req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    exp_q.push_back('{"b2b_st", 32'h0, 1'b0, cycle, 2});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!resp_valid) check("b2b_stall_busy", 32'(stall), 32'd1);
    end while (!resp_valid && n < 8);
    check("b2b_st_timeout", 32'(resp_valid), 32'd1);
    check("b2b_stall_done", 32'(stall), 32'd0);
    req_write = 1'b0;
    exp_q.push_back('{"b2b_ld", 32'hDEAD_BEEF, 1'b0, cycle + 1, 2});
    @(negedge clk);
    check("b2b_stall_idle", 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp("b2b_ld");
    check("b2b_mem", mem[16], 32'hDEAD_BEEF);
    check("b2b_we_count", we_count - wc, 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WIDTH, default `WIDTH (32) from the shared defines, giving the data and address width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: pipeline MEM-stage access request.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-007 SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-008 SHALL have ports req_addr and req_wdata, input, WIDTH each: byte address and store data, with data in the low bits.
REQ-009 SHALL have port stall, output, 1 bit: freezes the pipeline while an access is in flight.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, WIDTH: extended load result, valid with resp_valid.
REQ-012 SHALL have port misalign_err, output, 1 bit: completion flagged as misaligned or reserved-size.
REQ-013 SHALL have ports dmem_we (output, 1), dmem_addr (output, WIDTH), dmem_wdata (output, WIDTH) and dmem_rdata (input, WIDTH): the data-memory port.
- Memory is word-only.
- Write happens on the clk edge while dmem_we is high.
- Read is combinational from dmem_addr[WIDTH-1:2].

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR and DONE.
REQ-015 In IDLE with req_valid=1, SHALL latch all req_* fields at the clock edge and go to:
- DONE if misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11);
- WR for a word store;
- RD otherwise.
REQ-016 RD SHALL drive dmem_addr = {latched addr[WIDTH-1:2], 2'b00} and capture dmem_rdata at the edge, then go to:
- WR for sub-word stores;
- DONE for loads.
REQ-017 WR SHALL assert dmem_we for exactly one cycle, then go to DONE.
- Word store: dmem_wdata = req_wdata.
- Sub-word store: dmem_wdata = the captured word with only the addressed byte or half lanes replaced.
REQ-018 Byte lanes SHALL be little-endian: byte offset k occupies bits 8k+7:8k; half offset 2 occupies bits 31:16.
REQ-019 DONE SHALL last one cycle with resp_valid=1, then return to IDLE.
- resp_rdata = the extracted load value (zero for stores or errors).
- misalign_err = 1 only for a rejected request.
REQ-020 A rejected request SHALL never assert dmem_we.
REQ-021 stall SHALL be 1 when (state==IDLE and req_valid) or state is RD or WR; 0 in DONE and in IDLE without a request.
REQ-022 The requester SHALL hold req_* stable while stall=1; req_valid SHALL be ignored in DONE.
REQ-023 Latency from the accepting edge to the resp_valid cycle SHALL be:
- 1 cycle for misaligned requests;
- 2 cycles for loads and word stores;
- 3 cycles for sub-word stores.
REQ-024 dmem_we SHALL equal (state==WR) && !rst, so that no write occurs in any cycle where rst=1.
REQ-025 Outside RD and WR, dmem_addr and dmem_wdata SHALL still reflect the latched request (no X), with dmem_we=0.

Reset
REQ-026 On a clock edge with rst=1, the FSM SHALL go to IDLE and clear all latched fields.
- After that edge: stall=0 (if req_valid=0), resp_valid=0, resp_rdata=0, misalign_err=0, dmem_we=0.
REQ-027 Reset in RD or WR SHALL abort the access with no write and no response; the request is dropped.

Structure
REQ-028 The shared defines package SHALL hold WIDTH, the SIZE_BYTE/HALF/WORD/RSVD encodings and the FSM state encodings.
REQ-029 Byte-lane store-merge and load-extract/extension logic SHALL live in one combinational sub-module, lane_align.

Verification
REQ-030 Memory word 0x10 = 0x11223344, load byte signed at 0x12 -> resp_valid 2 cycles after accept, resp_rdata = 0x00000022.
REQ-031 Memory word 0x10 = 0x8899AABB:
- load half signed at 0x12 -> 0xFFFF8899;
- load half unsigned at 0x12 -> 0x00008899.
REQ-032 Memory word 0x20 = 0xAABBCCDD, store byte 0x5A at 0x21 -> exactly one dmem_we cycle, word becomes 0xAABB5ADD, resp_valid 3 cycles after accept.
REQ-033 Load word at 0x06 -> resp_valid after 1 cycle, misalign_err=1, dmem_we never asserted, memory unchanged.
REQ-034 Sub-word store with rst=1 asserted during the WR cycle -> no memory change, no resp_valid, FSM in IDLE next cycle.
REQ-035 Back-to-back word store 0xDEADBEEF to 0x40 then load word from 0x40 -> load returns 0xDEADBEEF; stall is low exactly one cycle (DONE) between them.
